// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SYNC   = 3'd1,
        ST_LEN_H  = 3'd2,
        ST_LEN_L  = 3'd3,
        ST_DATA_H = 3'd4,
        ST_DATA_L = 3'd5,
        ST_CSUM   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    // Bit period in clocks, rounded to nearest.
    function automatic int unsigned calc_bit_clks(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, start-bit glitch rejection.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int unsigned BIT_CLKS  = calc_bit_clks(CLK_HZ, BAUD);
    localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
    localparam int unsigned CNT_W     = $clog2(BIT_CLKS);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             r_meta, r_sync, r_prev;
    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid, r_ferr;
    logic [7:0]       r_data;
    logic             w_edge, w_half, w_full;

    assign w_edge = r_prev & ~r_sync;
    assign w_half = (r_cnt == CNT_W'(HALF_CLKS - 1));
    assign w_full = (r_cnt == CNT_W'(BIT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (w_edge) w_state_nxt = RX_START;
            // A start bit that is high again at mid-bit was a glitch.
            RX_START: if (w_half) w_state_nxt = r_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && r_bit == 3'd7) w_state_nxt = RX_STOP;
            RX_STOP:  if (w_full) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_valid <= 1'b0;
            r_data  <= 8'd0;
            r_ferr  <= 1'b0;
        end else begin
            r_meta  <= rx;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_valid <= 1'b0;
            if (r_state == RX_IDLE || w_state_nxt != r_state || (r_state == RX_DATA && w_full)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == RX_IDLE) begin
                r_bit <= 3'd0;
            end
            if (r_state == RX_DATA && w_full) begin
                r_shift <= {r_sync, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == RX_STOP && w_full) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
                r_ferr  <= ~r_sync;
            end
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_data;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: parses A5/LEN/words/CSUM frames into instruction RAM writes and holds
// the core in reset until a good checksum. Define PROG_LOADER_TIMEOUT_EN for an inter-byte timeout.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              load_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned HI_W      = DATA_W - 8;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    logic              w_byte_valid, w_frame_err;
    logic [7:0]        w_byte;
    state_e            r_state, w_state_nxt;
    logic [7:0]        r_len_h;
    logic [LEN_W-1:0]  r_len;
    logic [HI_W-1:0]   r_hi;
    logic [ADDR_W:0]   r_idx;
    logic [7:0]        r_csum;
    logic              r_wr_en, r_busy, r_done, r_err, r_cpu_rst;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              w_in_frame, w_byte_ok, w_len_bad, w_hi_bad, w_last;
    logic [LEN_W-1:0]  w_len_rx;
`ifdef PROG_LOADER_TIMEOUT_EN
    logic              w_tmo;
`endif

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte),
        .frame_err  (w_frame_err)
    );

    assign w_in_frame = (r_state != ST_RUN) && (r_state != ST_ERR);
    assign w_byte_ok  = w_byte_valid && !w_frame_err && w_in_frame && !load_req;
    assign w_len_rx   = {r_len_h, w_byte};
    assign w_len_bad  = (w_len_rx == '0) || (32'(w_len_rx) > MAX_WORDS);
    assign w_hi_bad   = (w_byte >> HI_W) != 8'd0;
    assign w_last     = (LEN_W'(r_idx) + LEN_W'(1)) == r_len;

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int unsigned BIT_CLKS = calc_bit_clks(CLK_HZ, BAUD);
    localparam int unsigned TMO_CLKS = 65536 * BIT_CLKS;
    localparam int unsigned TMO_W    = $clog2(TMO_CLKS);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Silence timer; SYNC is allowed to wait forever.
    always_ff @(posedge clk) begin
        if (rst || load_req || w_byte_valid || !w_in_frame || r_state == ST_SYNC) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo = (r_tmo_cnt == TMO_W'(TMO_CLKS - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (load_req) begin
            w_state_nxt = ST_SYNC;
        end else if (w_byte_valid && w_in_frame) begin
            if (w_frame_err) begin
                w_state_nxt = ST_ERR;
            end else begin
                case (r_state)
                    ST_SYNC:   if (w_byte == SYNC_BYTE) w_state_nxt = ST_LEN_H;
                    ST_LEN_H:  w_state_nxt = ST_LEN_L;
                    ST_LEN_L:  w_state_nxt = w_len_bad ? ST_ERR : ST_DATA_H;
                    ST_DATA_H: w_state_nxt = w_hi_bad ? ST_ERR : ST_DATA_L;
                    ST_DATA_L: w_state_nxt = w_last ? ST_CSUM : ST_DATA_H;
                    ST_CSUM:   w_state_nxt = (w_byte == r_csum) ? ST_RUN : ST_ERR;
                    default:   w_state_nxt = r_state;
                endcase
            end
        end
`ifdef PROG_LOADER_TIMEOUT_EN
        else if (w_tmo) begin
            w_state_nxt = ST_ERR;
        end
`endif
    end

    // Frame datapath, write port and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_h   <= 8'd0;
            r_len     <= '0;
            r_hi      <= '0;
            r_idx     <= '0;
            r_csum    <= 8'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_wr_en   <= 1'b0;
            r_busy    <= (w_state_nxt != ST_RUN) && (w_state_nxt != ST_ERR);
            r_err     <= (w_state_nxt == ST_ERR);
            r_cpu_rst <= (w_state_nxt != ST_RUN);
            if (load_req) begin
                r_idx  <= '0;
                r_csum <= 8'd0;
                r_done <= 1'b0;
            end else begin
                if (r_state == ST_CSUM && w_state_nxt == ST_RUN) begin
                    r_done <= 1'b1;
                end
                if (w_byte_ok) begin
                    case (r_state)
                        ST_LEN_H: begin
                            r_len_h <= w_byte;
                            r_csum  <= r_csum + w_byte;
                        end
                        ST_LEN_L: begin
                            r_len  <= w_len_rx;
                            r_csum <= r_csum + w_byte;
                        end
                        ST_DATA_H: begin
                            r_hi   <= w_byte[HI_W-1:0];
                            r_csum <= r_csum + w_byte;
                        end
                        ST_DATA_L: begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_idx[ADDR_W-1:0];
                            r_wr_data <= DATA_W'({r_hi, w_byte});
                            r_idx     <= r_idx + (ADDR_W+1)'(1);
                            r_csum    <= r_csum + w_byte;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign cpu_rst = r_cpu_rst;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames push expected writes/results, a monitor checks them.
module tb_prog_loader;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned BIT_CLKS = 32;
    localparam int unsigned CLK_HZ   = BAUD * BIT_CLKS;
    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, rx, load_req;
    logic        wr_en, cpu_rst, busy, done, err;
    logic [10:0] wr_addr;
    logic [13:0] wr_data;

    ev_t        exp_q[$];
    logic [7:0] frame[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic       mon_en = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;

    prog_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (11),
        .DATA_W (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .load_req (load_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input int addr, input int data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected event: got kind %0d addr %0h data %0h, expected nothing", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            chk("event kind", kind, e.kind);
            if (e.kind == EV_WR && kind == EV_WR) begin
                chk("wr_addr", addr, e.addr);
                chk("wr_data", data, e.data);
            end
        end
    endtask

    // Monitor: every write strobe and every rising done/err is matched against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) sb_pop(EV_WR, int'(wr_addr), int'(wr_data));
            if (done && !prev_done) begin
                sb_pop(EV_DONE, 0, 0);
                chk("cpu_rst released with done", int'(cpu_rst), 0);
            end
            if (err && !prev_err) begin
                sb_pop(EV_ERR, 0, 0);
                chk("cpu_rst held with err", int'(cpu_rst), 1);
            end
        end
        prev_done = done;
        prev_err  = err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT_CLKS);
        end
        rx = stop;
        tick(BIT_CLKS);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
    endtask

    task automatic exp_wr(input int a, input int d);
        exp_q.push_back('{EV_WR, a, d});
    endtask

    task automatic exp_ev(input int kind);
        exp_q.push_back('{kind, 0, 0});
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        chk("busy after load_req", int'(busy), 1);
        chk("cpu_rst after load_req", int'(cpu_rst), 1);
        chk("done cleared by load_req", int'(done), 0);
        chk("err cleared by load_req", int'(err), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * BIT_CLKS && exp_q.size() != 0; i++) tick(1);
        chk("scoreboard drained", exp_q.size(), 0);
    endtask

    task automatic chk_flags(input int e_done, input int e_err, input int e_rst);
        chk("done flag", int'(done), e_done);
        chk("err flag", int'(err), e_err);
        chk("cpu_rst level", int'(cpu_rst), e_rst);
        chk("busy idle", int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        load_req = 1'b0;
        tick(5);
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset wr_data", int'(wr_data), 0);
        chk("reset cpu_rst", int'(cpu_rst), 1);
        chk_flags(0, 0, 1);
        rst = 1'b0;
        tick(1);
        chk("cpu_rst after reset release", int'(cpu_rst), 0);
        mon_en = 1'b1;

        // Good load; checksum covers LEN bytes too: 02+30+05+3E+03 = 78.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h78};
        exp_wr(0, 'h3005); exp_wr(1, 'h3E03); exp_ev(EV_DONE);
        send_frame(); drain(); chk_flags(1, 0, 0);

        // Bad checksum: writes still land, core stays in reset.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h77};
        exp_wr(0, 'h3005); exp_wr(1, 'h3E03); exp_ev(EV_ERR);
        send_frame(); drain(); chk_flags(0, 1, 1);

        pulse_load();
        frame = {8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h78};
        exp_wr(0, 'h3005); exp_wr(1, 'h3E03); exp_ev(EV_DONE);
        send_frame(); drain(); chk_flags(1, 0, 0);

        // Zero length.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h00};
        exp_ev(EV_ERR);
        send_frame(); drain(); chk_flags(0, 1, 1);

        // Length 2049 exceeds the 2048-word RAM.
        pulse_load();
        frame = {8'hA5, 8'h08, 8'h01};
        exp_ev(EV_ERR);
        send_frame(); drain(); chk_flags(0, 1, 1);

        // High byte with bit 6 set.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h01, 8'h40, 8'h00};
        exp_ev(EV_ERR);
        send_frame(); drain(); chk_flags(0, 1, 1);

        // Noise before sync: 00+01+12+34 = 47.
        pulse_load();
        frame = {8'h12, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
        exp_wr(0, 'h1234); exp_ev(EV_DONE);
        send_frame(); drain(); chk_flags(1, 0, 0);

        // Short low glitch between LEN_L and the data must not become a byte: 00+01+00+2A = 2B.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h01};
        send_frame();
        rx = 1'b0; tick(10); rx = 1'b1; tick(3 * BIT_CLKS);
        frame = {8'h00, 8'h2A, 8'h2B};
        exp_wr(0, 'h002A); exp_ev(EV_DONE);
        send_frame(); drain(); chk_flags(1, 0, 0);

        // Stop bit forced low on the low data byte.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h01, 8'h3F};
        send_frame();
        exp_ev(EV_ERR);
        send_byte(8'h55, 1'b0);
        drain(); chk_flags(0, 1, 1);

        // rst after the first word.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h02};
        exp_wr(0, 'h0102);
        send_frame(); drain();
        rst = 1'b1;
        tick(1);
        chk("cpu_rst during rst", int'(cpu_rst), 1);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk_flags(0, 0, 0);
        chk("wr_en after rst", int'(wr_en), 0);

        // load_req mid-data restarts from address 0.
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h03, 8'h01, 8'h02};
        exp_wr(0, 'h0102);
        send_frame(); drain();
        pulse_load();
        frame = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
        exp_wr(0, 'h1234); exp_ev(EV_DONE);
        send_frame(); drain(); chk_flags(1, 0, 0);

        tick(4);
        chk("final scoreboard empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
